pe: RTL and testbench

PE -- requirements
Module: pe

---
 rtl/pe_if.sv | 26 ++
 rtl/pe.sv | 55 +++++
 tb/tb_pe.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/pe_if.sv
// pe_if: operand/result bundle for one weight-stationary processing element.
//   master : drives clear, weight_load, a_in, weight_in, psum_in; observes outputs
//   slave  : the PE side; observes the inputs and drives a_out, weight_out, psum_out
interface pe_if #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32
);
    logic              clear;
    logic              weight_load;
    logic [DATA_W-1:0] a_in;
    logic [DATA_W-1:0] weight_in;
    logic [ACC_W-1:0]  psum_in;
    logic [DATA_W-1:0] a_out;
    logic [DATA_W-1:0] weight_out;
    logic [ACC_W-1:0]  psum_out;

    modport master (
        output clear, weight_load, a_in, weight_in, psum_in,
        input  a_out, weight_out, psum_out
    );

    modport slave (
        input  clear, weight_load, a_in, weight_in, psum_in,
        output a_out, weight_out, psum_out
    );
endinterface

// File: rtl/pe.sv
// pe: weight-stationary MAC processing element, two pipeline stages.
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset, zeroes all state
//   bus  : pe_if slave
//     clear       - synchronous clear of psum stage registers (higher priority than MAC)
//     weight_load - capture weight_in into the stationary weight register
//     a_in/psum_in- operands, accepted every cycle
//     a_out       - a_in delayed one cycle, for the next PE
//     weight_out  - stationary weight
//     psum_out    - a*w + psum, two cycles after a_in/psum_in
module pe #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32
) (
    input logic clk,
    input logic rst,
    pe_if.slave bus
);
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   w_q, w_d;
    logic [ACC_W-1:0]    psum_q, psum_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [2*DATA_W-1:0] prod;
    logic [ACC_W-1:0]    prod_t;

    // Full-width product, then resized to the accumulator (truncate or zero-extend).
    assign prod   = {{DATA_W{1'b0}}, a_q} * {{DATA_W{1'b0}}, w_q};
    assign prod_t = ACC_W'(prod);

    always_comb begin
        a_d    = bus.a_in;
        w_d    = bus.weight_load ? bus.weight_in : w_q;
        // clear wins over the incoming psum and the MAC result; a/w are untouched
        psum_d = bus.clear ? '0 : bus.psum_in;
        acc_d  = bus.clear ? '0 : prod_t + psum_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q    <= '0;
            w_q    <= '0;
            psum_q <= '0;
            acc_q  <= '0;
        end else begin
            a_q    <= a_d;
            w_q    <= w_d;
            psum_q <= psum_d;
            acc_q  <= acc_d;
        end
    end

    assign bus.a_out      = a_q;
    assign bus.weight_out = w_q;
    assign bus.psum_out   = acc_q;
endmodule

// File: tb/tb_pe.sv
// tb_pe: scoreboard bench for pe, one ACC_W=32 and one ACC_W=8 instance
// driven by the same stimulus.
module tb_pe;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clear = 1'b0;
    logic        wl = 1'b0;
    logic [7:0]  a_in = '0;
    logic [7:0]  w_in = '0;
    logic [31:0] p_in = '0;
    int          cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pe_if #(.DATA_W(8), .ACC_W(32)) b32 ();
    pe_if #(.DATA_W(8), .ACC_W(8))  b8 ();

    assign b32.clear       = clear;
    assign b32.weight_load = wl;
    assign b32.a_in        = a_in;
    assign b32.weight_in   = w_in;
    assign b32.psum_in     = p_in;
    assign b8.clear        = clear;
    assign b8.weight_load  = wl;
    assign b8.a_in         = a_in;
    assign b8.weight_in    = w_in;
    assign b8.psum_in      = p_in[7:0];

    pe #(.DATA_W(8), .ACC_W(32)) u32 (.clk(clk), .rst(rst), .bus(b32.slave));
    pe #(.DATA_W(8), .ACC_W(8))  u8  (.clk(clk), .rst(rst), .bus(b8.slave));

    typedef struct {
        int          due;
        logic [31:0] e;
    } ent_t;
    ent_t q[$];

    int         total = 0;
    int         bad = 0;
    logic [7:0] wcur = '0;
    logic [7:0] prev_a = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    // Pop expected psum when its cycle comes up.
    always @(negedge clk) begin : mon
        ent_t e;
        while (q.size() > 0 && q[0].due < cyc) begin
            chk("sb_stale", q[0].due, cyc);
            void'(q.pop_front());
        end
        if (q.size() > 0 && q[0].due == cyc) begin
            e = q.pop_front();
            chk("psum32", b32.psum_out, e.e);
            chk("psum8", {24'd0, b8.psum_out}, {24'd0, e.e[7:0]});
        end
    end

    // One cycle of stimulus; also checks forwarding of the previous cycle.
    task automatic drive(input logic [7:0] a, input logic [31:0] p, input logic l,
                         input logic [7:0] w, input logic c);
        logic [31:0] e;
        @(negedge clk);
        chk("a_out32", {24'd0, b32.a_out}, {24'd0, prev_a});
        chk("a_out8",  {24'd0, b8.a_out},  {24'd0, prev_a});
        chk("w_out32", {24'd0, b32.weight_out}, {24'd0, wcur});
        chk("w_out8",  {24'd0, b8.weight_out},  {24'd0, wcur});
        a_in  = a;
        p_in  = p;
        wl    = l;
        w_in  = w;
        clear = c;
        if (l) wcur = w;
        if (c) begin
            foreach (q[i]) if (q[i].due == cyc + 1) q[i].e = '0;
        end
        e = 32'(a) * 32'(wcur) + (c ? 32'd0 : p);
        q.push_back('{due: cyc + 2, e: e});
        prev_a = a;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_a32"}, {24'd0, b32.a_out}, 32'd0);
        chk({tag, "_w32"}, {24'd0, b32.weight_out}, 32'd0);
        chk({tag, "_p32"}, b32.psum_out, 32'd0);
        chk({tag, "_a8"},  {24'd0, b8.a_out}, 32'd0);
        chk({tag, "_w8"},  {24'd0, b8.weight_out}, 32'd0);
        chk({tag, "_p8"},  {24'd0, b8.psum_out}, 32'd0);
    endtask

    // Asynchronous reset between edges; in-flight results are discarded.
    task automatic mid_reset();
        @(negedge clk);
        a_in = 8'hA5; w_in = 8'h77; wl = 1'b1; p_in = 32'd123; clear = 1'b1;
        #2 rst = 1'b1;
        #1 chk_zero("rst_async");
        q.delete();
        wcur = '0;
        prev_a = '0;
        @(negedge clk);
        a_in = '0; w_in = '0; wl = 1'b0; p_in = '0; clear = 1'b0;
        rst = 1'b0;
    endtask

    initial begin
        #12 chk_zero("rst_init");
        @(negedge clk);
        rst = 1'b0;

        // single MAC: w=3, a=5 -> 15
        drive(0, 0, 1, 3, 0);
        drive(5, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);

        // stream: w=2, a=1..5 -> 2,4,6,8,10
        drive(0, 0, 1, 2, 0);
        for (int i = 1; i <= 5; i++) drive(8'(i), 0, 0, 8'(i + 40), 0);

        // accumulate: w=3 -> 6,12,19
        drive(0, 0, 1, 3, 0);
        drive(2, 0, 0, 0, 0);
        drive(4, 0, 0, 0, 0);
        drive(3, 10, 0, 0, 0);

        // clear: w=5, a=4 held -> 20,20,0,20; weight_in wiggles without load
        drive(4, 0, 1, 5, 0);
        drive(4, 0, 0, 9, 0);
        drive(4, 0, 0, 9, 0);
        drive(4, 0, 0, 9, 1);
        drive(4, 0, 0, 0, 0);
        drive(4, 0, 0, 0, 0);

        // load and clear together
        drive(7, 50, 1, 6, 1);
        drive(1, 0, 0, 0, 0);

        // wrap: w=16, a=20 -> 320 (64 in 8 bits); then large psum wrap
        drive(0, 0, 1, 16, 0);
        drive(20, 0, 0, 0, 0);
        drive(255, 32'hFFFF_FFF0, 1, 255, 0);
        drive(255, 32'hFFFF_FFFF, 0, 0, 0);

        // mid-stream reset, then first load after reset
        drive(9, 3, 1, 11, 0);
        drive(8, 4, 0, 0, 0);
        mid_reset();
        drive(0, 0, 1, 3, 0);
        drive(5, 0, 0, 0, 0);
        drive(6, 1, 0, 0, 0);

        // random traffic
        for (int i = 0; i < 300; i++) begin
            if (i == 150) mid_reset();
            drive(8'($urandom), $urandom, ($urandom_range(3) == 0),
                  8'($urandom), ($urandom_range(15) == 0));
        end

        drive(0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        #1 chk("sb_empty", q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
